// File: rtl/gomoku_pkg.sv
// Shared board geometry, cell colour codes, checker state type and the
// board cell addressing helper used by every board reader.
package gomoku_pkg;

    localparam int BOARD_DIM  = 16;
    localparam int CELL_W     = 2;
    localparam int BOARD_BITS = BOARD_DIM * BOARD_DIM * CELL_W;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] BLACK = 2'b01;
    localparam logic [1:0] WHITE = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        SCAN_POS,
        SCAN_NEG,
        JUDGE,
        DONE
    } checkState_t;

    // Linear cell number row*BOARD_DIM+col; the cell occupies CELL_W bits
    // starting at cellIndex*CELL_W in the flattened board vector.
    function automatic logic [7:0] cellIndex(input logic [3:0] row, input logic [3:0] col);
        return 8'(row) * 8'(BOARD_DIM) + 8'(col);
    endfunction

endpackage

// File: rtl/board_cell_read.sv
// Combinational read port into the flattened board vector: selects the
// two-bit colour code of one {row,col} cell.
module board_cell_read
    import gomoku_pkg::*;
(
    input  logic [BOARD_BITS-1:0] board_i,
    input  logic [3:0]            row_i,
    input  logic [3:0]            col_i,
    output logic [CELL_W-1:0]     cell_o
);

    // Wide mux over all cells, addressed by the cell number.
    always_comb begin
        cell_o = board_i[int'(cellIndex(row_i, col_i)) * CELL_W +: CELL_W];
    end

endmodule

// File: rtl/line_run_check.sv
// One-direction win checker. Starting from the just-placed stone it walks
// outwards along +(DX,DY) and then -(DX,DY), counting stones of the placed
// colour, and reports either a win (success) or a hand-over to the next
// direction checker (active_next). The walk only advances while the
// sequencer holds 'active'; 'set' restarts it from a new placed cell.
module line_run_check
    import gomoku_pkg::*;
#(
    parameter int DX      = 1,
    parameter int DY      = 0,
    parameter int WIN_LEN = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  set,
    input  logic                  active,
    input  logic [7:0]            pointer,
    input  logic [1:0]            chess,
    input  logic [BOARD_BITS-1:0] board,
    output logic                  success,
    output logic                  active_next
);

    // Cursor steps are kept as 5-bit two's complement so that stepping off
    // either edge of the board lands on a value with bit 4 set (-1 or 16),
    // which is how off-board is detected without any wrap-around.
    localparam logic [4:0] STEP_COL = 5'(DX);
    localparam logic [4:0] STEP_ROW = 5'(DY);
    localparam logic [4:0] WIN_C    = 5'(WIN_LEN);

    checkState_t state_q, state_d;
    logic [3:0]  originRow_q, originRow_d;
    logic [3:0]  originCol_q, originCol_d;
    logic [1:0]  colour_q, colour_d;
    logic [4:0]  curRow_q, curRow_d;
    logic [4:0]  curCol_q, curCol_d;
    logic [4:0]  count_q, count_d;
    logic        success_q, success_d;
    logic        activeNext_q, activeNext_d;

    logic [1:0]  cellValue;
    logic        offBoard;
    logic        cellMatch;
    logic        canStep;
    logic [4:0]  originRowExt;
    logic [4:0]  originColExt;

    board_cell_read uCellRead (
        .board_i (board),
        .row_i   (curRow_q[3:0]),
        .col_i   (curCol_q[3:0]),
        .cell_o  (cellValue)
    );

    // Decide whether the cell under the cursor extends the run. An empty
    // placed colour never matches, so an empty "stone" can never win.
    always_comb begin
        originRowExt = {1'b0, originRow_q};
        originColExt = {1'b0, originCol_q};
        offBoard     = curRow_q[4] | curCol_q[4];
        cellMatch    = (colour_q != EMPTY) && (cellValue == colour_q);
        canStep      = !offBoard && cellMatch && (count_q != WIN_C);
    end

    // Next-state and datapath: set restarts everything, otherwise the walk
    // moves one cell per active cycle and freezes while active is low.
    always_comb begin
        state_d      = state_q;
        originRow_d  = originRow_q;
        originCol_d  = originCol_q;
        colour_d     = colour_q;
        curRow_d     = curRow_q;
        curCol_d     = curCol_q;
        count_d      = count_q;
        success_d    = success_q;
        activeNext_d = activeNext_q;

        if (set) begin
            state_d      = IDLE;
            success_d    = 1'b0;
            activeNext_d = 1'b0;
            originRow_d  = pointer[7:4];
            originCol_d  = pointer[3:0];
            colour_d     = chess;
            count_d      = (chess == EMPTY) ? 5'd0 : 5'd1;
        end else if (active) begin
            unique case (state_q)
                IDLE: begin
                    state_d  = SCAN_POS;
                    curRow_d = originRowExt + STEP_ROW;
                    curCol_d = originColExt + STEP_COL;
                end
                SCAN_POS: begin
                    if (canStep) begin
                        count_d  = count_q + 5'd1;
                        curRow_d = curRow_q + STEP_ROW;
                        curCol_d = curCol_q + STEP_COL;
                    end else begin
                        state_d  = SCAN_NEG;
                        curRow_d = originRowExt - STEP_ROW;
                        curCol_d = originColExt - STEP_COL;
                    end
                end
                SCAN_NEG: begin
                    if (canStep) begin
                        count_d  = count_q + 5'd1;
                        curRow_d = curRow_q - STEP_ROW;
                        curCol_d = curCol_q - STEP_COL;
                    end else begin
                        state_d = JUDGE;
                    end
                end
                JUDGE: begin
                    if (count_q >= WIN_C) begin
                        success_d = 1'b1;
                    end else begin
                        activeNext_d = 1'b1;
                    end
                    state_d = DONE;
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            originRow_q  <= 4'd0;
            originCol_q  <= 4'd0;
            colour_q     <= EMPTY;
            curRow_q     <= 5'd0;
            curCol_q     <= 5'd0;
            count_q      <= 5'd0;
            success_q    <= 1'b0;
            activeNext_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            originRow_q  <= originRow_d;
            originCol_q  <= originCol_d;
            colour_q     <= colour_d;
            curRow_q     <= curRow_d;
            curCol_q     <= curCol_d;
            count_q      <= count_d;
            success_q    <= success_d;
            activeNext_q <= activeNext_d;
        end
    end

    assign success     = success_q;
    assign active_next = activeNext_q;

endmodule

// File: tb/tb_line_run_check.sv
// Bench for line_run_check: a horizontal and a rising-diagonal checker
// share one set of inputs; a run-counting model predicts the result and
// the number of active cycles needed, and directed scenarios pin it.
module tb_line_run_check;
    import gomoku_pkg::*;

    localparam int WIN = 5;

    typedef struct packed {
        logic win;
        int   count;
        int   lat;
    } runRes_t;

    logic         clk;
    logic         resetn;
    logic         set;
    logic         active;
    logic [7:0]   pointer;
    logic [1:0]   chess;
    logic [511:0] board;
    logic         successH, activeNextH;
    logic         successD, activeNextD;

    int compared;
    int mismatched;

    logic    mValid;
    int      edgeCount;
    runRes_t hRes;
    runRes_t dRes;

    line_run_check #(.DX(1), .DY(0), .WIN_LEN(WIN)) dutH (
        .clk         (clk),
        .resetn      (resetn),
        .set         (set),
        .active      (active),
        .pointer     (pointer),
        .chess       (chess),
        .board       (board),
        .success     (successH),
        .active_next (activeNextH)
    );

    line_run_check #(.DX(1), .DY(-1), .WIN_LEN(WIN)) dutD (
        .clk         (clk),
        .resetn      (resetn),
        .set         (set),
        .active      (active),
        .pointer     (pointer),
        .chess       (chess),
        .board       (board),
        .success     (successD),
        .active_next (activeNextD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] cellAt(input logic [511:0] b, input int r, input int c);
        logic [1:0] v;
        v = b[(r * 16 + c) * 2 +: 2];
        return v;
    endfunction

    // Counts the run through the placed cell with plain integer walking:
    // stones counted in each direction (capped at WIN), and the number of
    // active cycles needed = start + each side's steps plus its exit + verdict.
    function automatic runRes_t modelRun(input logic [511:0] b, input logic [7:0] p,
                                         input logic [1:0] c, input int dx, input int dy);
        runRes_t res;
        int r;
        int cc;
        int cnt;
        int pos;
        int neg;
        cnt = (c == 2'b00) ? 0 : 1;
        pos = 0;
        neg = 0;
        r  = int'(p[7:4]) + dy;
        cc = int'(p[3:0]) + dx;
        while (c != 2'b00 && cnt < WIN && r >= 0 && r < 16 && cc >= 0 && cc < 16
               && cellAt(b, r, cc) == c) begin
            cnt++;
            pos++;
            r  += dy;
            cc += dx;
        end
        r  = int'(p[7:4]) - dy;
        cc = int'(p[3:0]) - dx;
        while (c != 2'b00 && cnt < WIN && r >= 0 && r < 16 && cc >= 0 && cc < 16
               && cellAt(b, r, cc) == c) begin
            cnt++;
            neg++;
            r  -= dy;
            cc -= dx;
        end
        res.win   = (cnt >= WIN);
        res.count = cnt;
        res.lat   = pos + neg + 4;
        return res;
    endfunction

    // Model bookkeeping: latch the expected run at each set, then count the
    // active cycles the checker has been given since.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mValid    <= 1'b0;
            edgeCount <= 0;
        end else if (set) begin
            mValid    <= 1'b1;
            edgeCount <= 0;
            hRes      <= modelRun(board, pointer, chess, 1, 0);
            dRes      <= modelRun(board, pointer, chess, 1, -1);
        end else if (active && mValid) begin
            edgeCount <= edgeCount + 1;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic compareLoop();
        logic expHS, expHA, expDS, expDA;
        forever begin
            @(negedge clk);
            expHS = mValid && (edgeCount >= hRes.lat) && hRes.win;
            expHA = mValid && (edgeCount >= hRes.lat) && !hRes.win;
            expDS = mValid && (edgeCount >= dRes.lat) && dRes.win;
            expDA = mValid && (edgeCount >= dRes.lat) && !dRes.win;
            checkOutput("cycle H success", int'(successH), int'(expHS));
            checkOutput("cycle H active_next", int'(activeNextH), int'(expHA));
            checkOutput("cycle D success", int'(successD), int'(expDS));
            checkOutput("cycle D active_next", int'(activeNextD), int'(expDA));
        end
    endtask

    task automatic putCell(input int r, input int c, input logic [1:0] v);
        board[(r * 16 + c) * 2 +: 2] = v;
    endtask

    // One-cycle set pulse latching a new placed cell; returns at posedge+2.
    task automatic applyStimulus(input logic [7:0] p, input logic [1:0] c);
        @(posedge clk);
        #2;
        pointer = p;
        chess   = c;
        set     = 1'b1;
        @(posedge clk);
        #2;
        set = 1'b0;
    endtask

    // Raise active and count edges until the chosen checker reports;
    // optionally drop active for three edges after edge 'holdAt'.
    task automatic runScan(input int holdAt, input bit useDiag, output int cycles);
        bit done;
        done   = 1'b0;
        cycles = 0;
        active = 1'b1;
        while (!done && cycles < 40) begin
            @(posedge clk);
            cycles++;
            #2;
            if (holdAt > 0 && cycles == holdAt) active = 1'b0;
            if (holdAt > 0 && cycles == holdAt + 3) active = 1'b1;
            done = useDiag ? (successD | activeNextD) : (successH | activeNextH);
        end
        if (!done) checkOutput("scan timeout", 0, 1);
        active = 1'b0;
    endtask

    task automatic loadRow7Win();
        board = '0;
        for (int c = 3; c <= 7; c++) putCell(7, c, BLACK);
    endtask

    initial begin
        int cyc;
        compared   = 0;
        mismatched = 0;
        resetn     = 1'b0;
        set        = 1'b0;
        active     = 1'b0;
        pointer    = 8'h00;
        chess      = 2'b00;
        board      = '0;
        fork
            compareLoop();
        join_none
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;
        #1;
        checkOutput("reset success", int'(successH), 0);
        checkOutput("reset active_next", int'(activeNextH), 0);
        checkOutput("reset count", int'(dutH.count_q), 0);

        // Horizontal five through (7,5)
        loadRow7Win();
        applyStimulus(8'h75, BLACK);
        checkOutput("model win count", hRes.count, 5);
        checkOutput("model win latency", hRes.lat, 8);
        runScan(0, 1'b0, cyc);
        checkOutput("win latency", cyc, 8);
        checkOutput("win success", int'(successH), 1);
        checkOutput("win active_next", int'(activeNextH), 0);
        checkOutput("win diag active_next", int'(activeNextD), 1);

        // Same, with active held low for three edges mid-scan
        applyStimulus(8'h75, BLACK);
        runScan(2, 1'b0, cyc);
        checkOutput("win held latency", cyc, 11);
        checkOutput("win held success", int'(successH), 1);

        // Only four in a row, white stone at col 7
        putCell(7, 7, WHITE);
        applyStimulus(8'h75, BLACK);
        checkOutput("model four count", hRes.count, 4);
        runScan(0, 1'b0, cyc);
        checkOutput("four latency", cyc, 7);
        checkOutput("four active_next", int'(activeNextH), 1);
        checkOutput("four success", int'(successH), 0);
        checkOutput("four count", int'(dutH.count_q), 4);

        // Row-wrap guard: stones continue on row 6 but must not join
        board = '0;
        putCell(5, 14, BLACK);
        putCell(5, 15, BLACK);
        putCell(6, 0, BLACK);
        putCell(6, 1, BLACK);
        putCell(6, 2, BLACK);
        applyStimulus(8'h5F, BLACK);
        checkOutput("model wrap count", hRes.count, 2);
        runScan(0, 1'b0, cyc);
        checkOutput("wrap latency", cyc, 5);
        checkOutput("wrap active_next", int'(activeNextH), 1);
        checkOutput("wrap success", int'(successH), 0);
        checkOutput("wrap count", int'(dutH.count_q), 2);

        // Rising diagonal five through (7,4)
        board = '0;
        putCell(9, 2, BLACK);
        putCell(8, 3, BLACK);
        putCell(7, 4, BLACK);
        putCell(6, 5, BLACK);
        putCell(5, 6, BLACK);
        applyStimulus(8'h74, BLACK);
        checkOutput("model diag latency", dRes.lat, 8);
        runScan(0, 1'b1, cyc);
        checkOutput("diag latency", cyc, 8);
        checkOutput("diag success", int'(successD), 1);
        checkOutput("diag active_next", int'(activeNextD), 0);

        // Restart mid-scan from a new pointer on the row-7 five
        loadRow7Win();
        applyStimulus(8'h75, BLACK);
        active = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        pointer = 8'h74;
        set     = 1'b1;
        @(posedge clk);
        #2;
        set = 1'b0;
        checkOutput("restart success cleared", int'(successH), 0);
        runScan(0, 1'b0, cyc);
        checkOutput("restart latency", cyc, 8);
        checkOutput("restart success", int'(successH), 1);
        @(posedge clk);
        #2;
        set = 1'b1;
        @(posedge clk);
        #2;
        set = 1'b0;
        checkOutput("set clears success", int'(successH), 0);

        // Asynchronous reset mid-scan and from DONE
        applyStimulus(8'h75, BLACK);
        active = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        resetn = 1'b0;
        active = 1'b0;
        #1;
        checkOutput("async reset count", int'(dutH.count_q), 0);
        @(posedge clk);
        #2;
        resetn = 1'b1;
        applyStimulus(8'h75, BLACK);
        runScan(0, 1'b0, cyc);
        checkOutput("pre-reset success", int'(successH), 1);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("async reset success", int'(successH), 0);
        @(posedge clk);
        #2;
        resetn = 1'b1;

        // Empty placed colour on an empty board
        board = '0;
        applyStimulus(8'h88, EMPTY);
        checkOutput("model empty count", hRes.count, 0);
        runScan(0, 1'b0, cyc);
        checkOutput("empty latency", cyc, 4);
        checkOutput("empty active_next", int'(activeNextH), 1);
        checkOutput("empty success", int'(successH), 0);
        applyStimulus(8'h88, EMPTY);
        runScan(2, 1'b0, cyc);
        checkOutput("empty held latency", cyc, 7);
        checkOutput("empty held active_next", int'(activeNextH), 1);

        repeat (3) @(posedge clk);
        #6;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
